axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter ID0, default 4'd0: ARID used for requester 0 (instruction cache).
REQ-002 SHALL have parameter ID1, default 4'd1: ARID used for requester 1 (data cache); ID1 != ID0.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, [1:0]: per-requester read burst request.
REQ-006 SHALL have port req_addr, input, 2 x ADDR_WIDTH: per-requester burst start address.
REQ-007 SHALL have port req_len, input, 2 x 4: per-requester AXI burst length (beats - 1).
REQ-008 SHALL have port req_ready, output, [1:0]: one-cycle pulse when the address handshake for that requester completes.
REQ-009 SHALL have port resp_valid, output, [1:0]: read beat valid for that requester.
REQ-010 SHALL have port resp_last, output, 1: final beat of the burst.
REQ-011 SHALL have port resp_data, output, DATA_WIDTH: beat data, shared by both requesters.
REQ-012 SHALL have port ar, axi_read_address.master: AXI read address channel to DRAM.
REQ-013 SHALL have port r, axi_read_data.master: AXI read data channel from DRAM.
REQ-014 SHALL have port proto_err, output, 1: sticky protocol-error flag.

Function
REQ-015 SHALL implement states IDLE, ADDR and DATA, with one burst outstanding at a time.
REQ-016 IDLE: when any req_valid bit is set, SHALL latch the grant index, req_addr and req_len, then move to ADDR on the next cycle.
REQ-017 Grant selection on simultaneous requests SHALL follow REQ-031/REQ-032; a single request SHALL be granted directly.
REQ-018 ADDR: ARVALID=1; ARADDR, ARLEN and ARID (ID0 or ID1 of the grant) SHALL come from registers and stay stable until ARREADY.
REQ-019 On ARVALID && ARREADY: req_ready[grant] SHALL pulse for exactly 1 cycle, ARVALID SHALL drop, the beat counter SHALL clear, and the state SHALL go to DATA.
REQ-020 Minimum latency SHALL be: req_valid seen in IDLE at cycle N gives ARVALID at N+1, and req_ready at N+1 if ARREADY is already high.
REQ-021 DATA: RREADY SHALL be 1 (requesters cannot back-pressure); RREADY SHALL be 0 in IDLE and ADDR.
REQ-022 resp_valid[grant] SHALL equal RVALID && state==DATA && RID==granted ID, combinationally; the other bit SHALL be 0.
REQ-023 resp_data SHALL be RDATA and resp_last SHALL be RLAST, passed through combinationally.
REQ-024 Each accepted beat SHALL increment a 4-bit beat counter.
REQ-025 A beat with RLAST=1 SHALL return the state to IDLE on the next cycle; a new grant SHALL then need at least one IDLE cycle.
REQ-026 proto_err SHALL set on: RLAST with counter != latched len; or counter == len without RLAST; or RVALID in DATA with RID != granted ID. The mismatched-RID beat SHALL still be accepted but not forwarded.
REQ-027 proto_err SHALL clear only on rst.
REQ-028 A requester SHALL hold req_valid, req_addr and req_len until its req_ready; a deasserted req_valid after the IDLE sample SHALL NOT cancel the burst.

Reset
REQ-029 While rst=1 the block SHALL force: state=IDLE, ARVALID=0, RREADY=0, req_ready=0, resp_valid=0, proto_err=0, beat counter=0, and priority pointer=requester 0.
REQ-030 rst asserted mid-ADDR or mid-DATA SHALL abandon the burst with no further req_ready or resp_valid pulses.

Configuration
REQ-031 With AXI_READ_ARB_ROUND_ROBIN_EN defined: on simultaneous requests, the requester not served last SHALL win, and the pointer SHALL update at RLAST.
REQ-032 Without AXI_READ_ARB_ROUND_ROBIN_EN: fixed priority, requester 1 (data cache) always wins, and the pointer logic SHALL be absent.

Structure
REQ-033 ADDR_WIDTH and DATA_WIDTH SHALL come from the shared core package.
REQ-034 The arbiter state enum and the requester-index typedef SHALL be added to the shared core package.
REQ-035 Grant selection SHALL be one sub-module, axi_read_arb_select (priority or round-robin picker); the rest SHALL be flat.

Verification
REQ-036 Single request: req_valid=2'b01, addr 0x100, len 3, ARREADY=1 -> ARVALID for 1 cycle with ARID 0, ARLEN 3, ARADDR 0x100; req_ready[0] pulses; 4 beats forwarded to resp_valid[0]; RLAST on beat 4; proto_err=0.
REQ-037 Contention, round-robin build: both requesters request continuously, len 0 -> grants alternate 1,0,1,0; fixed build -> every grant goes to 1.
REQ-038 ARREADY held low 5 cycles -> ARADDR, ARID and ARLEN stable, ARVALID held for 5 cycles, req_ready fires only on the handshake cycle.
REQ-039 Protocol errors: len 3 with RLAST on beat 2 -> proto_err=1, state back to IDLE; a separate run with RID=5 in DATA -> proto_err=1 and resp_valid stays 0 for that beat.
REQ-040 Reset during the 2nd beat of a DATA burst -> next cycle: IDLE, RREADY=0, no resp_valid; a subsequent request completes normally.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared core package for the AXI read arbiter.
// Provides the bus widths, the arbiter state enum, the requester-index
// type and a small helper that turns a requester index into a one-hot
// per-requester vector.
package axi_read_arbiter_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int ID_WIDTH   = 4;
  localparam int LEN_WIDTH  = 4;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  // Requester 0 = instruction cache, requester 1 = data cache.
  typedef logic req_idx_t;

  function automatic logic [1:0] idx_onehot(input req_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_if.sv
// AXI read channel interfaces used by the arbiter.
//   axi_read_address : arvalid/arready handshake plus araddr, arlen, arid.
//   axi_read_data    : rvalid/rready handshake plus rdata, rlast, rid.
// The master modport is the side that issues reads (the arbiter); the
// slave modport is the memory side.
interface axi_read_address;
  import axi_read_arbiter_pkg::*;

  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [LEN_WIDTH-1:0]  arlen;
  logic [ID_WIDTH-1:0]   arid;

  modport master (output arvalid, araddr, arlen, arid, input arready);
  modport slave  (input arvalid, araddr, arlen, arid, output arready);
endinterface

interface axi_read_data;
  import axi_read_arbiter_pkg::*;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic [ID_WIDTH-1:0]   rid;

  modport master (input rvalid, rdata, rlast, rid, output rready);
  modport slave  (output rvalid, rdata, rlast, rid, input rready);
endinterface

// File: rtl/axi_read_arb_select.sv
// Grant picker for the two-requester AXI read arbiter.
// Build option: AXI_READ_ARB_ROUND_ROBIN_EN
//   defined   : on simultaneous requests the requester not served last wins.
//   undefined : fixed priority, requester 1 (data cache) always wins.
// Ports:
//   req_valid  : per-requester request bits
//   last_grant : requester served by the most recent burst (round-robin only)
//   grant      : selected requester (meaningful only when req_valid != 0)
module axi_read_arb_select
  import axi_read_arbiter_pkg::*;
(
  input  logic [1:0] req_valid,
`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
  input  req_idx_t   last_grant,
`endif
  output req_idx_t   grant
);

  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
      grant = ~last_grant;
`else
      grant = 1'b1;
`endif
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter (instruction cache = 0, data cache = 1).
// One burst is outstanding at a time: IDLE latches the winning request,
// ADDR presents it on the AR channel, DATA forwards R beats to the winner.
// Build option: AXI_READ_ARB_ROUND_ROBIN_EN selects round-robin grants
// (pointer updated at RLAST); otherwise requester 1 has fixed priority.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/addr/len : per-requester burst request (held until req_ready)
//   req_ready       : one-cycle pulse on the AR handshake for the winner
//   resp_valid      : per-requester beat valid; resp_data/resp_last shared
//   ar, r           : AXI read address / read data channels to DRAM
//   proto_err       : sticky flag for RLAST/length or RID mismatches
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter logic [ID_WIDTH-1:0] ID0 = 4'd0,
  parameter logic [ID_WIDTH-1:0] ID1 = 4'd1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req_valid,
  input  logic [1:0][ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0][LEN_WIDTH-1:0]  req_len,
  output logic [1:0]                 req_ready,
  output logic [1:0]                 resp_valid,
  output logic                       resp_last,
  output logic [DATA_WIDTH-1:0]      resp_data,
  axi_read_address.master            ar,
  axi_read_data.master               r,
  output logic                       proto_err
);

  arb_state_t            state;
  req_idx_t              sel;
  req_idx_t              grant;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  err_q;
  logic                  in_data;
  logic                  id_match;
  logic                  ar_hs;

`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
  req_idx_t last_grant;

  axi_read_arb_select u_select (
    .req_valid  (req_valid),
    .last_grant (last_grant),
    .grant      (sel)
  );
`else
  axi_read_arb_select u_select (
    .req_valid (req_valid),
    .grant     (sel)
  );
`endif

  // Outputs are gated by rst so nothing leaks out during the reset cycle,
  // before the registered state has been cleared.
  assign in_data    = (state == ARB_DATA) & ~rst;
  assign id_match   = (r.rid == id_q);
  assign ar_hs      = arvalid_q & ar.arready & ~rst;

  assign ar.arvalid = arvalid_q & ~rst;
  assign ar.araddr  = addr_q;
  assign ar.arlen   = len_q;
  assign ar.arid    = id_q;
  assign r.rready   = in_data;

  assign req_ready  = ar_hs ? idx_onehot(grant) : 2'b00;
  assign resp_valid = (in_data & r.rvalid & id_match) ? idx_onehot(grant) : 2'b00;
  assign resp_data  = r.rdata;
  assign resp_last  = r.rlast;
  assign proto_err  = err_q & ~rst;

  // Request capture: data-path registers, only loaded on a grant in IDLE.
  always_ff @(posedge clk) begin
    if (state == ARB_IDLE && |req_valid) begin
      grant  <= sel;
      addr_q <= req_addr[sel];
      len_q  <= req_len[sel];
      id_q   <= sel ? ID1 : ID0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      arvalid_q <= 1'b0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|req_valid) begin
            state     <= ARB_ADDR;
            arvalid_q <= 1'b1;
          end
        end
        ARB_ADDR: begin
          if (ar.arready) begin
            arvalid_q <= 1'b0;
            beat_cnt  <= '0;
            state     <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (r.rvalid) begin
            beat_cnt <= beat_cnt + 4'd1;
            // RLAST must coincide exactly with the beat whose index equals
            // the latched length; a foreign RID is consumed but flagged.
            if (!id_match || (r.rlast != (beat_cnt == len_q))) begin
              err_q <= 1'b1;
            end
            if (r.rlast) begin
              state <= ARB_IDLE;
`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
              last_grant <= grant;
`endif
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: directed cases for the single
// request, AR stall, contention, protocol errors and mid-burst reset,
// followed by randomized bursts compared against a transaction-level model.
module tb_axi_read_arbiter;
  import axi_read_arbiter_pkg::*;

  localparam logic [3:0] ID0 = 4'd0;
  localparam logic [3:0] ID1 = 4'd1;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [1:0]                 req_valid;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][LEN_WIDTH-1:0]  req_len;
  logic [1:0]                 req_ready;
  logic [1:0]                 resp_valid;
  logic                       resp_last;
  logic [DATA_WIDTH-1:0]      resp_data;
  logic                       proto_err;

  axi_read_address ar_if ();
  axi_read_data    r_if ();

  axi_read_arbiter #(.ID0(ID0), .ID1(ID1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_last  (resp_last),
    .resp_data  (resp_data),
    .ar         (ar_if),
    .r          (r_if),
    .proto_err  (proto_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: who was served last, and whether an error was seen.
  int last_srv = 0;
  bit err_exp  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(input logic [1:0] rv);
    if (rv == 2'b11) begin
`ifdef AXI_READ_ARB_ROUND_ROBIN_EN
      return 1 - last_srv;
`else
      return 1;
`endif
    end
    return rv[1] ? 1 : 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    ar_if.arready = 1'b0;
    r_if.rvalid = 1'b0;
    r_if.rlast = 1'b0;
    #1;
    chk("rst_arvalid", ar_if.arvalid, 0);
    chk("rst_proto_err", proto_err, 0);
    @(negedge clk);
    rst = 1'b0;
    last_srv = 0;
    err_exp = 1'b0;
  endtask

  task automatic idle_check();
    @(negedge clk);
    req_valid = 2'b00;
    ar_if.arready = 1'b0;
    r_if.rvalid = 1'b0;
    r_if.rlast = 1'b0;
    #1;
    chk("idle_rready", r_if.rready, 0);
    chk("idle_arvalid", ar_if.arvalid, 0);
    chk("idle_proto_err", proto_err, err_exp);
  endtask

  // One complete request/burst. rlast_at: beat index carrying RLAST;
  // bad_beat: beat index returned with RID=5 (-1 none); rst_beat: beat
  // index during which rst is asserted (-1 none).
  task automatic do_burst(input logic [1:0] rv, input logic [31:0] a0, input logic [31:0] a1,
                          input logic [3:0] l0, input logic [3:0] l1, input int ar_delay,
                          input int rlast_at, input int bad_beat, input int rst_beat);
    int          g;
    logic [3:0]  len;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] d;
    bit          done;
    int          gap;
    g    = pick(rv);
    len  = (g == 1) ? l1 : l0;
    addr = (g == 1) ? a1 : a0;
    id   = (g == 1) ? ID1 : ID0;

    @(negedge clk);
    req_valid = rv;
    req_addr[0] = a0;
    req_addr[1] = a1;
    req_len[0] = l0;
    req_len[1] = l1;
    ar_if.arready = 1'b0;
    r_if.rvalid = 1'b0;
    r_if.rlast = 1'b0;
    #1;
    chk("idle_arvalid", ar_if.arvalid, 0);
    chk("idle_rready", r_if.rready, 0);
    chk("proto_err", proto_err, err_exp);

    for (int k = 0; k <= ar_delay; k++) begin
      @(negedge clk);
      ar_if.arready = (k == ar_delay);
      #1;
      chk("arvalid", ar_if.arvalid, 1);
      chk("araddr", ar_if.araddr, addr);
      chk("arlen", ar_if.arlen, len);
      chk("arid", ar_if.arid, id);
      chk("req_ready", req_ready, (k == ar_delay) ? (64'd1 << g) : 64'd0);
      chk("addr_rready", r_if.rready, 0);
    end

    done = 1'b0;
    for (int i = 0; !done; i++) begin
      gap = $urandom_range(0, 2);
      for (int j = 0; j < gap; j++) begin
        @(negedge clk);
        ar_if.arready = 1'b0;
        r_if.rvalid = 1'b0;
        req_valid[g] = 1'b0;
        #1;
        chk("gap_rready", r_if.rready, 1);
        chk("gap_resp_valid", resp_valid, 0);
        chk("gap_arvalid", ar_if.arvalid, 0);
      end
      @(negedge clk);
      ar_if.arready = 1'b0;
      req_valid[g] = 1'b0;
      d = $urandom;
      r_if.rvalid = 1'b1;
      r_if.rdata = d;
      r_if.rlast = (i == rlast_at);
      r_if.rid = (i == bad_beat) ? 4'd5 : id;
      if (i == rst_beat) begin
        rst = 1'b1;
        #1;
        chk("rstbeat_resp_valid", resp_valid, 0);
        chk("rstbeat_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        req_valid = 2'b00;
        #1;
        chk("postrst_rready", r_if.rready, 0);
        chk("postrst_arvalid", ar_if.arvalid, 0);
        chk("postrst_resp_valid", resp_valid, 0);
        chk("postrst_proto_err", proto_err, 0);
        r_if.rvalid = 1'b0;
        r_if.rlast = 1'b0;
        last_srv = 0;
        err_exp = 1'b0;
        done = 1'b1;
      end else begin
        #1;
        chk("data_rready", r_if.rready, 1);
        chk("resp_valid", resp_valid, (i == bad_beat) ? 64'd0 : (64'd1 << g));
        chk("resp_data", resp_data, d);
        chk("resp_last", resp_last, (i == rlast_at));
        if (i == bad_beat) err_exp = 1'b1;
        if ((i == rlast_at) != (i == int'(len))) err_exp = 1'b1;
        if (i == rlast_at) begin
          done = 1'b1;
          last_srv = g;
        end
      end
    end
  endtask

  initial begin
    logic [1:0]  rv;
    logic [3:0]  l0;
    logic [3:0]  l1;
    rst = 1'b1;
    req_valid = 2'b00;
    req_addr = '0;
    req_len = '0;
    ar_if.arready = 1'b0;
    r_if.rvalid = 1'b0;
    r_if.rdata = '0;
    r_if.rlast = 1'b0;
    r_if.rid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_arvalid", ar_if.arvalid, 0);
    chk("reset_rready", r_if.rready, 0);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_proto_err", proto_err, 0);

    // Single request from the instruction cache.
    do_burst(2'b01, 32'h100, 32'h0, 4'd3, 4'd0, 0, 3, -1, -1);
    // AR channel stalled for five cycles.
    do_burst(2'b10, 32'h0, 32'h2000, 4'd0, 4'd2, 5, 2, -1, -1);
    // Contention with len 0 on both sides.
    for (int n = 0; n < 4; n++) begin
      do_burst(2'b11, 32'h40 + n, 32'h80 + n, 4'd0, 4'd0, 0, 0, -1, -1);
    end
    // Randomized traffic.
    for (int n = 0; n < 25; n++) begin
      rv = 2'($urandom_range(1, 3));
      l0 = 4'($urandom_range(0, 7));
      l1 = 4'($urandom_range(0, 7));
      do_burst(rv, $urandom, $urandom, l0, l1, $urandom_range(0, 3),
               (rv == 2'b11 ? int'(pick(rv) == 1 ? l1 : l0) : int'(rv[1] ? l1 : l0)), -1, -1);
    end
    idle_check();

    // Early RLAST: len 3, RLAST on the second beat.
    do_burst(2'b01, 32'h300, 32'h0, 4'd3, 4'd0, 0, 1, -1, -1);
    idle_check();
    do_reset();
    // Foreign RID on the second beat.
    do_burst(2'b10, 32'h0, 32'h400, 4'd0, 4'd3, 1, 3, 1, -1);
    idle_check();
    do_reset();
    // Reset during the second beat, then a normal burst.
    do_burst(2'b01, 32'h500, 32'h0, 4'd3, 4'd0, 0, 3, -1, 1);
    do_burst(2'b01, 32'h600, 32'h0, 4'd2, 4'd0, 1, 2, -1, -1);
    idle_check();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
